// File: rtl/barret_pkg.sv
// rtl/barret_pkg.sv - shared constants and sweep state type for the Barrett q=3779 checker
package barret_pkg;

    localparam int Q     = 3779;
    localparam int IN_W  = 23;
    localparam int OUT_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/mod_wrap_counter.sv
// rtl/mod_wrap_counter.sv - modulo-Q up counter that wraps Q-1 back to 0
module mod_wrap_counter #(
    parameter int Q     = 3779,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [OUT_W-1:0] value
);

    logic [OUT_W-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= (r_value == OUT_W'(Q - 1)) ? '0 : r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/barret_3779_sweep_checker.sv
// rtl/barret_3779_sweep_checker.sv - sweeps reducer operand 0..limit and checks residue against a wrap counter
module barret_3779_sweep_checker #(
    parameter int Q      = barret_pkg::Q,
    parameter int IN_W   = barret_pkg::IN_W,
    parameter int OUT_W  = barret_pkg::OUT_W,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  limit,
    output logic [IN_W-1:0]  din_a,
    input  logic [OUT_W-1:0] dout_r,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_count,
    output logic [IN_W-1:0]  first_err_in,
    output logic [OUT_W-1:0] first_err_got
);

    import barret_pkg::*;

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    sweep_state_t     r_state;
    sweep_state_t     w_next;
    logic [IN_W-1:0]  r_idx;
    logic [IN_W-1:0]  r_limit;
    logic [SET_W-1:0] r_settle;
    logic [IN_W:0]    r_err_count;
    logic [IN_W-1:0]  r_first_in;
    logic [OUT_W-1:0] r_first_got;
    logic [OUT_W-1:0] w_exp;
    logic             w_start_ok;
    logic             w_settled;
    logic             w_last;
    logic             w_mismatch;
    logic             w_inc;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_settled  = (r_settle == SET_W'(SETTLE - 1));
    assign w_last     = (r_idx == r_limit);
    assign w_mismatch = (r_state == SAMPLE) && (dout_r != w_exp);
    assign w_inc      = (r_state == SAMPLE) && !w_last;

    mod_wrap_counter #(
        .Q     (Q),
        .OUT_W (OUT_W)
    ) u_exp (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start_ok),
        .inc   (w_inc),
        .value (w_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = DRIVE;
            DRIVE:      if (w_settled) w_next = SAMPLE;
            SAMPLE:     w_next = w_last ? DONE : DRIVE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == DRIVE) || (r_state == SAMPLE);
        done = (r_state == DONE);
        pass = (r_state == DONE) && (r_err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_limit     <= '0;
            r_settle    <= '0;
            r_err_count <= '0;
            r_first_in  <= '0;
            r_first_got <= '0;
        end else if (w_start_ok) begin
            r_idx       <= '0;
            r_limit     <= limit;
            r_settle    <= '0;
            r_err_count <= '0;
            r_first_in  <= '0;
            r_first_got <= '0;
        end else if (r_state == DRIVE) begin
            r_settle <= w_settled ? '0 : r_settle + 1'b1;
        end else if (r_state == SAMPLE) begin
            // Only the first mismatch of a sweep is latched; the count saturates
            if (w_mismatch) begin
                if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
                if (r_err_count == '0) begin
                    r_first_in  <= r_idx;
                    r_first_got <= dout_r;
                end
            end
            if (!w_last) r_idx <= r_idx + 1'b1;
        end
    end

    assign din_a         = r_idx;
    assign err_count     = r_err_count;
    assign first_err_in  = r_first_in;
    assign first_err_got = r_first_got;

endmodule

// File: tb/tb_barret_3779_sweep_checker.sv
// tb/tb_barret_3779_sweep_checker.sv - scoreboard bench with behavioural reducer models and randomized sweeps
module tb_barret_3779_sweep_checker;

    localparam int Q     = 3779;
    localparam int IN_W  = 23;
    localparam int OUT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IN_W-1:0]  limit;
    logic [IN_W-1:0]  din_a;
    logic [OUT_W-1:0] dout_r;
    logic             busy;
    logic             done;
    logic             pass;
    logic [IN_W:0]    err_count;
    logic [IN_W-1:0]  first_err_in;
    logic [OUT_W-1:0] first_err_got;

    int mode  = 0;
    int fk    = 2;
    int fr    = 0;
    int fmask = 1;

    typedef struct {
        int err;
        int first_in;
        int first_got;
        int pass;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    bit   prev_done = 1'b0;

    always #5 clk = ~clk;

    barret_3779_sweep_checker #(
        .Q      (Q),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SETTLE (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .limit         (limit),
        .din_a         (din_a),
        .dout_r        (dout_r),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_in  (first_err_in),
        .first_err_got (first_err_got)
    );

    // Reducer stand-ins: 0 ideal, 1 wrong only at 3779, 2 stuck-at-0, 3 sparse random corruption
    function automatic int model_red(int a, int m, int k, int r, int mask);
        int v;
        v = a % Q;
        case (m)
            1:       if (a == 3779) v = 5;
            2:       v = 0;
            3:       if ((a % k) == r) v = (v ^ mask) & 12'hFFF;
            default: v = a % Q;
        endcase
        return v;
    endfunction

    assign dout_r = OUT_W'(model_red(int'(din_a), mode, fk, fr, fmask));

    function automatic exp_t predict(int lim);
        exp_t e;
        int   g;
        e.err = 0; e.first_in = 0; e.first_got = 0;
        for (int i = 0; i <= lim; i++) begin
            g = model_red(i, mode, fk, fr, fmask);
            if (g != (i % Q)) begin
                if (e.err == 0) begin
                    e.first_in  = i;
                    e.first_got = g;
                end
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.lat  = (lim + 1) * 2;
        return e;
    endfunction

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) busy_cnt = 0;
        else if (busy) busy_cnt++;
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("err_count", longint'(err_count), e.err);
                chk("first_err_in", longint'(first_err_in), e.first_in);
                chk("first_err_got", longint'(first_err_got), e.first_got);
                chk("pass", longint'(pass), e.pass);
                chk("latency", busy_cnt, e.lat);
            end
            busy_cnt = 0;
        end
        prev_done = done;
    end

    task automatic kick(int lim);
        @(negedge clk);
        limit = IN_W'(lim);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic run(int lim, int m, int k, int r, int mask);
        mode = m; fk = k; fr = r; fmask = mask;
        sb.push_back(predict(lim));
        kick(lim);
        wait_done((lim + 1) * 2 + 20);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        limit = '0;
        repeat (3) @(negedge clk);
        chk("rst_din_a", longint'(din_a), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_pass", longint'(pass), 0);
        chk("rst_err_count", longint'(err_count), 0);
        chk("rst_first_in", longint'(first_err_in), 0);
        chk("rst_first_got", longint'(first_err_got), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        run(3778, 0, 2, 0, 1);
        run(7557, 0, 2, 0, 1);
        run(4000, 1, 2, 0, 1);
        run(9, 2, 2, 0, 1);

        // Restart from DONE with limit=0 must clear the previous error count
        mode = 0;
        sb.push_back(predict(0));
        kick(0);
        chk("restart_err_cleared", longint'(err_count), 0);
        chk("restart_done_low", longint'(done), 0);
        wait_done(20);

        // start and limit changes while busy must not disturb the sweep
        mode = 0;
        sb.push_back(predict(20));
        kick(20);
        limit = IN_W'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(80);

        // Reset in the middle of a failing sweep discards everything
        mode = 2;
        kick(3778);
        repeat (99) @(negedge clk);
        chk("pre_rst_err_nonzero", longint'(err_count != 0), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_done", longint'(done), 0);
        chk("midrst_din_a", longint'(din_a), 0);
        chk("midrst_err_count", longint'(err_count), 0);
        chk("midrst_first_in", longint'(first_err_in), 0);
        rst = 1'b0;
        run(50, 0, 2, 0, 1);

        for (int t = 0; t < 6; t++) begin
            int lim, m, k, r, mask;
            lim  = int'($urandom_range(0, 1200));
            m    = ($urandom_range(0, 2) == 0) ? 0 : 3;
            k    = int'($urandom_range(2, 60));
            r    = int'($urandom_range(0, k - 1));
            mask = int'($urandom_range(1, 4095));
            run(lim, m, k, r, mask);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
